// File: rtl/bus_cs_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bus_map_pkg
// Purpose  : Region codes, chip-select indices and FSM state encoding shared
//            by the bus chip-select decoder and its interface.
// Revision : 1.0 - initial release
// ============================================================================
package bus_map_pkg;

  // Width of the region field taken from the top of ADDR.
  localparam int REGION_W = 3;
  localparam int NUM_CS   = 6;

  // Region codes; 6 and 7 are both unmapped, REG_UNMAP names the first.
  localparam logic [REGION_W-1:0] REG_UART0 = 3'd0;
  localparam logic [REGION_W-1:0] REG_UART1 = 3'd1;
  localparam logic [REGION_W-1:0] REG_UART2 = 3'd2;
  localparam logic [REGION_W-1:0] REG_UART3 = 3'd3;
  localparam logic [REGION_W-1:0] REG_PIC   = 3'd4;
  localparam logic [REGION_W-1:0] REG_CONS  = 3'd5;
  localparam logic [REGION_W-1:0] REG_UNMAP = 3'd6;

  // Access sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_e;

  // One-hot chip select vector: bit 0 UART0 ... bit 5 CONS; unmapped -> none.
  function automatic logic [NUM_CS-1:0] region_to_cs(input logic [REGION_W-1:0] region);
    logic [NUM_CS-1:0] cs;
    cs = '0;
    case (region)
      REG_UART0: cs[0] = 1'b1;
      REG_UART1: cs[1] = 1'b1;
      REG_UART2: cs[2] = 1'b1;
      REG_UART3: cs[3] = 1'b1;
      REG_PIC:   cs[4] = 1'b1;
      REG_CONS:  cs[5] = 1'b1;
      default:   cs = '0;
    endcase
    return cs;
  endfunction

endpackage : bus_map_pkg
`default_nettype wire

// File: rtl/bus_cs_decoder_if.sv
`default_nettype none
// ============================================================================
// Interface : bus_cs_decoder_if
// Purpose   : CPU static-bus strobes/address in, peripheral chip selects,
//             direction, strobes and wait control out.
// Revision  : 1.0 - initial release
// ============================================================================
interface bus_cs_decoder_if #(
  parameter int ABW = 7
);
  logic           nCS;
  logic           nOE;
  logic           nWE;
  logic [ABW:0]   ADDR;
  logic           CSUART0;
  logic           CSUART1;
  logic           CSUART2;
  logic           CSUART3;
  logic           CSPIC;
  logic           CSCONS;
  logic           nRW;
  logic           RDSTB;
  logic           WRSTB;
  logic           nWAIT;
  logic           TOERR;

  // CPU side: drives strobes and address, observes decoder outputs.
  modport master (
    output nCS, nOE, nWE, ADDR,
    input  CSUART0, CSUART1, CSUART2, CSUART3, CSPIC, CSCONS,
    input  nRW, RDSTB, WRSTB, nWAIT, TOERR
  );

  // Decoder side.
  modport slave (
    input  nCS, nOE, nWE, ADDR,
    output CSUART0, CSUART1, CSUART2, CSUART3, CSPIC, CSCONS,
    output nRW, RDSTB, WRSTB, nWAIT, TOERR
  );
endinterface : bus_cs_decoder_if
`default_nettype wire

// File: rtl/bus_cs_decoder_sync2.sv
`default_nettype none
// ============================================================================
// Module   : sync2
// Purpose  : Two-flop synchroniser for an active-low async strobe; resets to
//            1 so a strobe reads as inactive until really sampled low.
// Revision : 1.0 - initial release
// ============================================================================
module sync2 (
  input  wire  logic clk,
  input  wire  logic rst,
  input  wire  logic d,
  output logic       q
);
  logic meta_q;

  // Two back-to-back flops; the first may go metastable, the second is used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      q      <= 1'b1;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end
endmodule : sync2
`default_nettype wire

// File: rtl/bus_cs_decoder.sv
`default_nettype none
// ============================================================================
// Module   : bus_cs_decoder
// Purpose  : Synchronises the CPU static-bus strobes, decodes the region into
//            one-hot chip selects, paces the CPU via nWAIT and issues
//            single-cycle read/write strobes to the peripherals.
// Options  : BUS_TIMEOUT_EN - abandon a HOLD that lasts TOW cycles and pulse
//            TOERR; otherwise HOLD waits for nCS indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
module bus_cs_decoder
  import bus_map_pkg::*;
#(
  parameter int ABW = 7,
  parameter int WS  = 2,
  parameter int TOW = 255
) (
  input  wire logic        CLK,
  input  wire logic        RESET,
  bus_cs_decoder_if.slave  bus
);

  localparam logic [3:0] WS_CNT = 4'(WS);

  logic ncs_s, noe_s, nwe_s;
  logic start_w;

  state_e                state_q,    state_d;
  logic [REGION_W-1:0]   region_q,   region_d;
  logic [NUM_CS-1:0]     cs_q,       cs_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic                  nrw_q,      nrw_d;
  logic                  nwait_q,    nwait_d;
  logic                  rdstb_q,    rdstb_d;
  logic                  wrstb_q,    wrstb_d;

  sync2 u_sync_ncs (.clk(CLK), .rst(RESET), .d(bus.nCS), .q(ncs_s));
  sync2 u_sync_noe (.clk(CLK), .rst(RESET), .d(bus.nOE), .q(noe_s));
  sync2 u_sync_nwe (.clk(CLK), .rst(RESET), .d(bus.nWE), .q(nwe_s));

`ifdef BUS_TIMEOUT_EN
  localparam int TOW_W = (TOW < 2) ? 1 : $clog2(TOW + 1);
  logic [TOW_W-1:0] tout_cnt_q, tout_cnt_d;
  logic             toerr_q,    toerr_d;
  // After a timeout the CPU must release nCS before another access starts.
  logic             release_q,  release_d;

  assign start_w = ~ncs_s & (~noe_s | ~nwe_s) & ~release_q;
`else
  assign start_w = ~ncs_s & (~noe_s | ~nwe_s);
`endif

  // Next-state and next-output computation for the access sequencer.
  always_comb begin
    state_d    = state_q;
    region_d   = region_q;
    cs_d       = cs_q;
    wait_cnt_d = wait_cnt_q;
    nrw_d      = nrw_q;
    nwait_d    = nwait_q;
    rdstb_d    = 1'b0;
    wrstb_d    = 1'b0;
`ifdef BUS_TIMEOUT_EN
    tout_cnt_d = tout_cnt_q;
    toerr_d    = 1'b0;
    release_d  = release_q & ~ncs_s;
`endif
    case (state_q)
      IDLE: begin
        if (start_w) begin
          // Address is only trusted once the strobes have been synchronised.
          region_d = bus.ADDR[ABW -: REGION_W];
          nrw_d    = noe_s;   // read wins if nOE and nWE are both low
          nwait_d  = 1'b0;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        if (ncs_s) begin
          cs_d    = '0;
          nrw_d   = 1'b1;
          nwait_d = 1'b1;
          state_d = IDLE;
        end else begin
          cs_d       = region_to_cs(region_q);
          wait_cnt_d = WS_CNT;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (ncs_s) begin
          cs_d    = '0;
          nrw_d   = 1'b1;
          nwait_d = 1'b1;
          state_d = IDLE;
        end else if (wait_cnt_q != 4'd0) begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end else begin
          nwait_d = 1'b1;
          // Unmapped regions have no CS and therefore get no strobe.
          if (cs_q != '0) begin
            rdstb_d = ~nrw_q;
            wrstb_d = nrw_q;
          end
`ifdef BUS_TIMEOUT_EN
          tout_cnt_d = TOW_W'(TOW);
`endif
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ncs_s) begin
          cs_d    = '0;
          nrw_d   = 1'b1;
          state_d = IDLE;
        end
`ifdef BUS_TIMEOUT_EN
        else if (tout_cnt_q <= TOW_W'(1)) begin
          cs_d      = '0;
          nrw_d     = 1'b1;
          toerr_d   = 1'b1;
          release_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tout_cnt_d = tout_cnt_q - TOW_W'(1);
        end
`endif
      end
      default: begin
        cs_d    = '0;
        nrw_d   = 1'b1;
        nwait_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; async reset returns to the idle bus state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      region_q   <= '0;
      cs_q       <= '0;
      wait_cnt_q <= '0;
      nrw_q      <= 1'b1;
      nwait_q    <= 1'b1;
      rdstb_q    <= 1'b0;
      wrstb_q    <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      tout_cnt_q <= '0;
      toerr_q    <= 1'b0;
      release_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      region_q   <= region_d;
      cs_q       <= cs_d;
      wait_cnt_q <= wait_cnt_d;
      nrw_q      <= nrw_d;
      nwait_q    <= nwait_d;
      rdstb_q    <= rdstb_d;
      wrstb_q    <= wrstb_d;
`ifdef BUS_TIMEOUT_EN
      tout_cnt_q <= tout_cnt_d;
      toerr_q    <= toerr_d;
      release_q  <= release_d;
`endif
    end
  end

  assign bus.CSUART0 = cs_q[0];
  assign bus.CSUART1 = cs_q[1];
  assign bus.CSUART2 = cs_q[2];
  assign bus.CSUART3 = cs_q[3];
  assign bus.CSPIC   = cs_q[4];
  assign bus.CSCONS  = cs_q[5];
  assign bus.nRW     = nrw_q;
  assign bus.RDSTB   = rdstb_q;
  assign bus.WRSTB   = wrstb_q;
  assign bus.nWAIT   = nwait_q;
`ifdef BUS_TIMEOUT_EN
  assign bus.TOERR   = toerr_q;
`else
  assign bus.TOERR   = 1'b0;
`endif

endmodule : bus_cs_decoder
`default_nettype wire

// File: tb/tb_bus_cs_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_cs_decoder
// Purpose  : Self-checking bench for bus_cs_decoder (ABW=7, WS=2, TOW=10).
//            Expected access outcomes are queued when an access is launched
//            and compared against what the DUT produced once it completes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_cs_decoder;

  localparam int ABW = 7;
  localparam int WS  = 2;
  localparam int TOW = 10;

  typedef struct {
    logic [5:0] cs;         // OR of all CS seen
    int         lat;        // edges from strobe drive to first CS
    int         wait_low;   // sampled cycles with nWAIT low
    int         rd;         // RDSTB high cycles
    int         wr;         // WRSTB high cycles
    int         viol;       // cycles with more than one CS high
    logic       hold_nrw;   // nRW while holding
    logic [5:0] cs_after;   // CS after release
    logic       nrw_after;
    logic       tmo;        // access never completed
  } acc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  acc_t sb[$];

  bus_cs_decoder_if #(.ABW(ABW)) bus ();

  bus_cs_decoder #(.ABW(ABW), .WS(WS), .TOW(TOW)) u_dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] cs_vec();
    return {bus.CSCONS, bus.CSPIC, bus.CSUART3, bus.CSUART2, bus.CSUART1, bus.CSUART0};
  endfunction

  task automatic bus_idle();
    bus.nCS  = 1'b1;
    bus.nOE  = 1'b1;
    bus.nWE  = 1'b1;
    bus.ADDR = '0;
  endtask

  task automatic drive_start(input logic [2:0] region, input logic rd);
    bus.ADDR            = '0;
    bus.ADDR[ABW -: 3]  = region;
    bus.nCS             = 1'b0;
    bus.nOE             = ~rd;
    bus.nWE             = rd;
  endtask

  // Runs one full access (start, hold a few cycles, release) and records it.
  task automatic run_access(input logic [2:0] region, input logic rd, output acc_t o);
    int   cyc;
    int   after;
    logic seen_low;
    logic [5:0] cs;
    o = '{cs: '0, lat: 0, wait_low: 0, rd: 0, wr: 0, viol: 0, hold_nrw: 1'b1,
          cs_after: '0, nrw_after: 1'b0, tmo: 1'b0};
    cyc = 0; after = 0; seen_low = 1'b0;
    drive_start(region, rd);
    while (after < 4 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      cs = cs_vec();
      if (cs != '0 && o.lat == 0) o.lat = cyc;
      if ($countones(cs) > 1) o.viol++;
      o.cs = o.cs | cs;
      if (!bus.nWAIT) begin o.wait_low++; seen_low = 1'b1; end
      if (bus.RDSTB) o.rd++;
      if (bus.WRSTB) o.wr++;
      if (seen_low && bus.nWAIT) begin after++; o.hold_nrw = bus.nRW; end
    end
    if (after < 4) o.tmo = 1'b1;
    bus_idle();
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.RDSTB) o.rd++;
      if (bus.WRSTB) o.wr++;
    end
    o.cs_after  = cs_vec();
    o.nrw_after = bus.nRW;
  endtask

  // Launch an access, queue its expected outcome, then compare when done.
  task automatic test_access(input string name, input logic [2:0] region, input logic rd);
    acc_t e;
    acc_t g;
    e.cs        = (region < 3'd6) ? (6'd1 << region) : 6'd0;
    e.lat       = (region < 3'd6) ? 4 : 0;
    e.wait_low  = WS + 2;
    e.rd        = (region < 3'd6 && rd) ? 1 : 0;
    e.wr        = (region < 3'd6 && !rd) ? 1 : 0;
    e.viol      = 0;
    e.hold_nrw  = ~rd;
    e.cs_after  = '0;
    e.nrw_after = 1'b1;
    e.tmo       = 1'b0;
    sb.push_back(e);
    run_access(region, rd, g);
    e = sb.pop_front();
    n_total++; if (g.tmo !== e.tmo) $display("FAIL %s done: got tmo=%0b want %0b", name, g.tmo, e.tmo); else n_pass++;
    n_total++; if (g.cs !== e.cs) $display("FAIL %s cs: got %b want %b", name, g.cs, e.cs); else n_pass++;
    n_total++; if (g.lat !== e.lat) $display("FAIL %s cs_latency: got %0d want %0d", name, g.lat, e.lat); else n_pass++;
    n_total++; if (g.viol !== e.viol) $display("FAIL %s onehot: got %0d multi-CS cycles want %0d", name, g.viol, e.viol); else n_pass++;
    n_total++; if (g.wait_low !== e.wait_low) $display("FAIL %s nwait_low: got %0d want %0d", name, g.wait_low, e.wait_low); else n_pass++;
    n_total++; if (g.rd !== e.rd) $display("FAIL %s rdstb: got %0d want %0d", name, g.rd, e.rd); else n_pass++;
    n_total++; if (g.wr !== e.wr) $display("FAIL %s wrstb: got %0d want %0d", name, g.wr, e.wr); else n_pass++;
    n_total++; if (g.hold_nrw !== e.hold_nrw) $display("FAIL %s hold_nrw: got %b want %b", name, g.hold_nrw, e.hold_nrw); else n_pass++;
    n_total++; if (g.cs_after !== e.cs_after) $display("FAIL %s cs_release: got %b want %b", name, g.cs_after, e.cs_after); else n_pass++;
    n_total++; if (g.nrw_after !== e.nrw_after) $display("FAIL %s nrw_release: got %b want %b", name, g.nrw_after, e.nrw_after); else n_pass++;
  endtask

  task automatic test_reset();
    logic [9:0] got;
    repeat (2) @(posedge clk);
    #1;
    got = {cs_vec(), bus.nRW, bus.RDSTB, bus.WRSTB, bus.nWAIT};
    n_total++; if (got !== 10'b000000_1_0_0_1) $display("FAIL reset_outputs: got %b want %b", got, 10'b000000_1_0_0_1); else n_pass++;
    n_total++; if (bus.TOERR !== 1'b0) $display("FAIL reset_toerr: got %b want 0", bus.TOERR); else n_pass++;
    rst = 1'b0;
  endtask

  // nCS raised right after DECODE: the sequencer must abort in ACCESS.
  task automatic test_abort();
    int strobes;
    int low;
    strobes = 0; low = 0;
    drive_start(3'd1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (bus.nWAIT !== 1'b0) $display("FAIL abort_wait_start: got %b want 0", bus.nWAIT); else n_pass++;
    bus_idle();
    @(posedge clk); #1;
    n_total++; if (cs_vec() !== 6'b000010) $display("FAIL abort_cs_access: got %b want %b", cs_vec(), 6'b000010); else n_pass++;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.RDSTB || bus.WRSTB) strobes++;
    end
    n_total++; if ({cs_vec(), bus.nWAIT, bus.nRW} !== 8'b000000_1_1)
      $display("FAIL abort_outputs: got %b want %b", {cs_vec(), bus.nWAIT, bus.nRW}, 8'b000000_1_1); else n_pass++;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.RDSTB || bus.WRSTB) strobes++;
      if (!bus.nWAIT) low++;
    end
    n_total++; if (strobes !== 0) $display("FAIL abort_no_strobe: got %0d strobes want 0", strobes); else n_pass++;
    n_total++; if (low !== 0) $display("FAIL abort_stays_idle: got %0d wait cycles want 0", low); else n_pass++;
  endtask

  // Asynchronous reset while in ACCESS, then a clean access afterwards.
  task automatic test_reset_mid();
    int strobes;
    strobes = 0;
    drive_start(3'd0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    n_total++; if ({cs_vec(), bus.nWAIT} !== 7'b000001_0) $display("FAIL rstmid_in_access: got %b want %b", {cs_vec(), bus.nWAIT}, 7'b000001_0); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if ({cs_vec(), bus.nRW, bus.RDSTB, bus.WRSTB, bus.nWAIT} !== 10'b000000_1_0_0_1)
      $display("FAIL rstmid_async: got %b want %b", {cs_vec(), bus.nRW, bus.RDSTB, bus.WRSTB, bus.nWAIT}, 10'b000000_1_0_0_1); else n_pass++;
    bus_idle();
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.RDSTB || bus.WRSTB) strobes++;
    end
    rst = 1'b0;
    n_total++; if (strobes !== 0) $display("FAIL rstmid_no_strobe: got %0d want 0", strobes); else n_pass++;
    test_access("after_reset_uart3_rd", 3'd3, 1'b1);
  endtask

  // HOLD with nCS kept low: waits forever by default, times out when enabled.
  task automatic test_hold();
    int   cyc;
    int   toerr_at;
    int   toerr_n;
    int   low;
    logic [5:0] cs12;
    logic nrw12;
    cyc = 0; toerr_at = 0; toerr_n = 0; low = 0;
    drive_start(3'd5, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    while (!bus.nWAIT && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_total++; if (bus.nWAIT !== 1'b1) $display("FAIL hold_entry: got nWAIT=%b want 1", bus.nWAIT); else n_pass++;
    cs12 = '0; nrw12 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.TOERR) begin toerr_n++; if (toerr_at == 0) toerr_at = k; end
      if (!bus.nWAIT) low++;
      if (k == 12) begin cs12 = cs_vec(); nrw12 = bus.nRW; end
    end
`ifdef BUS_TIMEOUT_EN
    n_total++; if (toerr_at !== TOW) $display("FAIL hold_toerr_time: got %0d want %0d", toerr_at, TOW); else n_pass++;
    n_total++; if (toerr_n !== 1) $display("FAIL hold_toerr_width: got %0d want 1", toerr_n); else n_pass++;
    n_total++; if (cs12 !== 6'b000000) $display("FAIL hold_cs_cleared: got %b want %b", cs12, 6'b000000); else n_pass++;
    n_total++; if (low !== 0) $display("FAIL hold_no_reaccess: got %0d wait cycles want 0", low); else n_pass++;
`else
    n_total++; if (toerr_n !== 0) $display("FAIL hold_toerr_tied: got %0d want 0", toerr_n); else n_pass++;
    n_total++; if (cs12 !== 6'b100000) $display("FAIL hold_cs_held: got %b want %b", cs12, 6'b100000); else n_pass++;
    n_total++; if (low !== 0) $display("FAIL hold_nwait: got %0d wait cycles want 0", low); else n_pass++;
`endif
    n_total++; if (nrw12 !== 1'b1) $display("FAIL hold_nrw: got %b want 1", nrw12); else n_pass++;
    bus_idle();
    repeat (4) @(posedge clk);
    #1;
    n_total++; if (cs_vec() !== 6'b000000) $display("FAIL hold_release: got %b want %b", cs_vec(), 6'b000000); else n_pass++;
  endtask

  task automatic test_back_to_back();
    test_access("b2b_uart0_wr", 3'd0, 1'b0);
    test_access("b2b_cons_rd", 3'd5, 1'b1);
    test_access("b2b_unmap6_wr", 3'd6, 1'b0);
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_access("uart2_rd", 3'd2, 1'b1);
    test_access("pic_wr", 3'd4, 1'b0);
    test_access("unmap7_rd", 3'd7, 1'b1);
    test_abort();
    test_reset_mid();
    test_hold();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_bus_cs_decoder
`default_nettype wire
